// File: rtl/seg_disp_pkg.sv
// Shared constants, types and helpers for the 7-segment display readback path.
// Segment patterns are ordered [6]=a down to [0]=g.
package seg_disp_pkg;

    localparam int NUM_DIGITS = 6;

    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b1011111;
    localparam logic [6:0] SEG_7     = 7'b1110000;
    localparam logic [6:0] SEG_7_ALT = 7'b1110010;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1111011;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    localparam logic [3:0] DIG_BLANK = 4'hA;
    localparam logic [3:0] DIG_BAD   = 4'hF;

    typedef struct packed {
        logic [NUM_DIGITS*4-1:0] digits;
        logic [NUM_DIGITS-1:0]   dp;
    } frame_t;

    function automatic logic is_one_hot(input logic [NUM_DIGITS-1:0] v);
        return (v != '0) && ((v & (v - 1'b1)) == '0);
    endfunction

    function automatic logic [2:0] one_hot_idx(input logic [NUM_DIGITS-1:0] v);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/seg7_to_bcd.sv
// Combinational segment-pattern decoder: digits 0-9, blank, or a bad-pattern flag.
module seg7_to_bcd
    import seg_disp_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] code,
    output logic       bad
);

    always_comb begin
        code = DIG_BAD;
        bad  = 1'b0;
        unique case (seg)
            SEG_0:     code = 4'd0;
            SEG_1:     code = 4'd1;
            SEG_2:     code = 4'd2;
            SEG_3:     code = 4'd3;
            SEG_4:     code = 4'd4;
            SEG_5:     code = 4'd5;
            SEG_6:     code = 4'd6;
            SEG_7:     code = 4'd7;
            SEG_7_ALT: code = 4'd7;
            SEG_8:     code = 4'd8;
            SEG_9:     code = 4'd9;
            SEG_BLANK: code = DIG_BLANK;
            default:   bad  = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg_disp_decoder.sv
// Reconstructs a 6-digit multiplexed 7-segment display into BCD digits and DP flags,
// publishing a frame only once it has repeated unchanged for STABLE_FRAMES scans.
module seg_disp_decoder
    import seg_disp_pkg::*;
#(
    parameter int   SETTLE        = 4,
    parameter int   STABLE_FRAMES = 2,
    parameter int   TIMEOUT       = 65535,
    parameter logic ENB_POL       = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [6:0]              i_seg,
    input  logic                    i_seg_dp,
    input  logic [NUM_DIGITS-1:0]   i_seg_enb,
    output logic [NUM_DIGITS*4-1:0] o_digits,
    output logic [NUM_DIGITS-1:0]   o_dp,
    output logic                    o_valid,
    output logic                    o_err,
    output logic                    o_lost
);

    localparam int SW  = $clog2(SETTLE + 1);
    localparam int STW = $clog2(STABLE_FRAMES + 1);
    localparam int TW  = $clog2(TIMEOUT + 1);

    localparam logic [SW-1:0]  SETTLE_LAST = SW'(SETTLE - 1);
    localparam logic [STW-1:0] STAB_MAX    = STW'(STABLE_FRAMES);
    localparam logic [TW-1:0]  TO_MAX      = TW'(TIMEOUT);
    localparam logic [TW-1:0]  TO_LAST     = TW'(TIMEOUT - 1);

    logic [6:0]            seg_q;
    logic                  dp_q;
    logic [NUM_DIGITS-1:0] en_q;
    logic [NUM_DIGITS-1:0] en_d;
    logic [SW-1:0]         settle_cnt;
    logic                  sampled;
    frame_t                cap;
    frame_t                prev;
    logic                  prev_valid;
    logic [NUM_DIGITS-1:0] cap_mask;
    logic [STW-1:0]        stab_cnt;
    logic [TW-1:0]         to_cnt;

    logic [3:0]            code;
    logic                  bad;
    logic                  changed;
    logic                  one_hot;
    logic                  multi;
    logic [SW-1:0]         eff_cnt;
    logic                  eff_done;
    logic                  do_sample;
    logic [2:0]            slot;
    logic [NUM_DIGITS-1:0] slot_bit;
    logic                  frame_done;
    logic                  frames_equal;
    logic [STW-1:0]        stab_next;
    logic                  publish;

    seg7_to_bcd u_dec (
        .seg  (seg_q),
        .code (code),
        .bad  (bad)
    );

    // The counter view is taken as zero on the very cycle the enable changes, so a
    // dwell of exactly SETTLE cycles yields one sample on its last cycle.
    always_comb begin
        changed      = (en_q != en_d);
        one_hot      = is_one_hot(en_q);
        multi        = (en_q != '0) && !one_hot;
        eff_cnt      = changed ? '0 : settle_cnt;
        eff_done     = changed ? 1'b0 : sampled;
        do_sample    = one_hot && !eff_done && (eff_cnt == SETTLE_LAST);
        slot         = one_hot_idx(en_q);
        slot_bit     = NUM_DIGITS'(1) << slot;
        frame_done   = (cap_mask == '1) && !multi;
        frames_equal = prev_valid && (cap == prev);
        stab_next    = STW'(1);
        if (frames_equal) begin
            stab_next = (stab_cnt == STAB_MAX) ? stab_cnt : stab_cnt + 1'b1;
        end
        publish = frame_done && (stab_next == STAB_MAX)
                  && !(frames_equal && (stab_cnt == STAB_MAX));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seg_q      <= '0;
            dp_q       <= 1'b0;
            en_q       <= '0;
            en_d       <= '0;
            settle_cnt <= '0;
            sampled    <= 1'b0;
            cap        <= '0;
            cap_mask   <= '0;
        end else begin
            seg_q <= i_seg;
            dp_q  <= i_seg_dp;
            en_q  <= i_seg_enb ^ {NUM_DIGITS{~ENB_POL}};
            en_d  <= en_q;
            if (one_hot) begin
                settle_cnt <= (eff_cnt == SETTLE_LAST) ? eff_cnt : eff_cnt + 1'b1;
                sampled    <= eff_done || do_sample;
            end else begin
                settle_cnt <= '0;
                sampled    <= 1'b0;
            end
            if (do_sample) begin
                cap.digits[{slot, 2'b00} +: 4] <= code;
                cap.dp[slot]                   <= dp_q;
            end
            // An illegal enable throws away whatever part of the frame was collected.
            if (multi) begin
                cap_mask <= '0;
            end else begin
                cap_mask <= (frame_done ? '0 : cap_mask) | (do_sample ? slot_bit : '0);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev       <= '0;
            prev_valid <= 1'b0;
            stab_cnt   <= '0;
            to_cnt     <= '0;
            o_digits   <= '0;
            o_dp       <= '0;
            o_valid    <= 1'b0;
            o_err      <= 1'b0;
            o_lost     <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            o_err   <= (multi && changed) || (do_sample && bad);
            if (frame_done) begin
                prev       <= cap;
                prev_valid <= 1'b1;
                stab_cnt   <= stab_next;
                to_cnt     <= '0;
                o_lost     <= 1'b0;
                if (publish) begin
                    o_digits <= cap.digits;
                    o_dp     <= cap.dp;
                    o_valid  <= 1'b1;
                end
            end else if (to_cnt != TO_MAX) begin
                to_cnt <= to_cnt + 1'b1;
                if (to_cnt == TO_LAST) begin
                    o_lost   <= 1'b1;
                    stab_cnt <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_seg_disp_decoder.sv
// Directed bench for seg_disp_decoder: table of scanned frames plus hand sequences
// for illegal enables, timeout, publish latency and mid-frame reset.
module tb_seg_disp_decoder;

    localparam int SETTLE  = 4;
    localparam int STABLE  = 2;
    localparam int TIMEOUT = 300;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  i_seg = '0;
    logic        i_seg_dp = 1'b0;
    logic [5:0]  i_seg_enb = 6'h3F;
    logic [23:0] o_digits;
    logic [5:0]  o_dp;
    logic        o_valid;
    logic        o_err;
    logic        o_lost;

    int checks = 0;
    int errors = 0;
    int valid_seen = 0;
    int err_seen = 0;
    int err_wide = 0;
    logic err_last = 1'b0;

    typedef struct {
        logic [23:0] sym;
        logic [5:0]  dp;
        int          reps;
        int          pub_frame;
        logic [23:0] exp_digits;
        logic [5:0]  exp_dp;
        int          exp_err;
    } vec_t;

    vec_t vecs[6];

    seg_disp_decoder #(
        .SETTLE        (SETTLE),
        .STABLE_FRAMES (STABLE),
        .TIMEOUT       (TIMEOUT),
        .ENB_POL       (1'b0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_seg     (i_seg),
        .i_seg_dp  (i_seg_dp),
        .i_seg_enb (i_seg_enb),
        .o_digits  (o_digits),
        .o_dp      (o_dp),
        .o_valid   (o_valid),
        .o_err     (o_err),
        .o_lost    (o_lost)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (o_valid) valid_seen++;
        if (o_err) begin
            err_seen++;
            if (err_last) err_wide++;
        end
        err_last = o_err;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Symbol A = blank, B = alternate 7 pattern, F = an undecodable pattern.
    function automatic logic [6:0] seg_of(input logic [3:0] s);
        case (s)
            4'h0: return 7'h7E;
            4'h1: return 7'h30;
            4'h2: return 7'h6D;
            4'h3: return 7'h79;
            4'h4: return 7'h33;
            4'h5: return 7'h5B;
            4'h6: return 7'h5F;
            4'h7: return 7'h70;
            4'h8: return 7'h7F;
            4'h9: return 7'h7B;
            4'hA: return 7'h00;
            4'hB: return 7'h72;
            default: return 7'h41;
        endcase
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input int idx, input logic [3:0] sym, input logic dp, input int dwell);
        logic [5:0] one;
        one       = 6'b1 << idx;
        i_seg     = seg_of(sym);
        i_seg_dp  = dp;
        i_seg_enb = ~one;
        repeat (dwell) tick;
        i_seg_enb = 6'h3F;
        i_seg     = '0;
        i_seg_dp  = 1'b0;
        tick;
    endtask

    task automatic scan_digits(input logic [23:0] sym, input logic [5:0] dp, input int last);
        for (int d = 5; d >= last; d--) applyStimulus(d, sym[d*4 +: 4], dp[d], SETTLE);
    endtask

    task automatic scan_frame(input logic [23:0] sym, input logic [5:0] dp);
        scan_digits(sym, dp, 0);
        repeat (4) tick;
    endtask

    task automatic do_reset;
        rst       = 1'b1;
        i_seg_enb = 6'h3F;
        i_seg     = '0;
        i_seg_dp  = 1'b0;
        tick;
        tick;
        rst = 1'b0;
    endtask

    initial begin
        int v0;
        int e0;

        vecs[0] = '{24'h654321, 6'b000100, 3,  1, 24'h654321, 6'b000100, 0};
        vecs[1] = '{24'h654327, 6'b000100, 2,  1, 24'h654327, 6'b000100, 0};
        vecs[2] = '{24'h65F327, 6'b000100, 2,  1, 24'h65F327, 6'b000100, 2};
        vecs[3] = '{24'h80B9AA, 6'b100001, 3,  1, 24'h8079AA, 6'b100001, 0};
        vecs[4] = '{24'h80B9AA, 6'b100001, 2, -1, 24'h8079AA, 6'b100001, 0};
        vecs[5] = '{24'h8079AA, 6'b100001, 2, -1, 24'h8079AA, 6'b100001, 0};

        do_reset();
        checkOutput("reset o_digits", o_digits, 0);
        checkOutput("reset o_dp", o_dp, 0);
        checkOutput("reset o_valid", o_valid, 0);
        checkOutput("reset o_err", o_err, 0);
        checkOutput("reset o_lost", o_lost, 0);

        for (int i = 0; i < 6; i++) begin
            e0 = err_seen;
            for (int f = 0; f < vecs[i].reps; f++) begin
                v0 = valid_seen;
                scan_frame(vecs[i].sym, vecs[i].dp);
                checkOutput($sformatf("vec%0d frame%0d valid", i, f), valid_seen - v0,
                            (f == vecs[i].pub_frame) ? 1 : 0);
            end
            checkOutput($sformatf("vec%0d o_digits", i), o_digits, vecs[i].exp_digits);
            checkOutput($sformatf("vec%0d o_dp", i), o_dp, vecs[i].exp_dp);
            checkOutput($sformatf("vec%0d err pulses", i), err_seen - e0, vecs[i].exp_err);
        end
        checkOutput("table o_lost", o_lost, 0);

        // Too-short dwells capture nothing; o_lost rises TIMEOUT cycles after release.
        do_reset();
        v0 = valid_seen;
        e0 = err_seen;
        for (int d = 0; d < 6; d++) applyStimulus(d, 4'(d + 1), 1'b0, SETTLE - 1);
        for (int n = 6 * SETTLE + 1; n <= TIMEOUT + 1; n++) begin
            tick;
            if (n == TIMEOUT - 1) checkOutput("lost before timeout", o_lost, 0);
            if (n == TIMEOUT)     checkOutput("lost at timeout", o_lost, 1);
            if (n == TIMEOUT + 1) checkOutput("lost holds", o_lost, 1);
        end
        checkOutput("short dwell valid", valid_seen - v0, 0);
        checkOutput("short dwell err", err_seen - e0, 0);
        checkOutput("short dwell o_digits", o_digits, 0);
        scan_frame(24'h445566, 6'b000000);
        checkOutput("lost cleared by frame", o_lost, 0);
        checkOutput("first frame after lost valid", valid_seen - v0, 0);

        // Publish latency: o_valid exactly two cycles after the last digit sample.
        scan_digits(24'h445566, 6'b000000, 1);
        i_seg     = seg_of(4'h6);
        i_seg_dp  = 1'b0;
        i_seg_enb = 6'h3E;
        for (int n = 1; n <= 7; n++) begin
            tick;
            if (n == SETTLE) begin
                i_seg_enb = 6'h3F;
                i_seg     = '0;
            end
            checkOutput($sformatf("latency o_valid @%0d", n), o_valid, (n == 6) ? 1 : 0);
        end
        checkOutput("latency o_digits", o_digits, 24'h445566);

        // Two enables at once discard the partial frame.
        e0 = err_seen;
        v0 = valid_seen;
        scan_digits(24'h112233, 6'b000000, 1);
        i_seg_enb = ~6'b000011;
        repeat (3) tick;
        i_seg_enb = 6'h3F;
        repeat (3) tick;
        checkOutput("multi-hot err pulses", err_seen - e0, 1);
        applyStimulus(0, 4'h3, 1'b0, SETTLE);
        repeat (4) tick;
        checkOutput("discarded frame valid", valid_seen - v0, 0);
        v0 = valid_seen;
        scan_frame(24'h112233, 6'b000000);
        checkOutput("after discard frame1 valid", valid_seen - v0, 0);
        v0 = valid_seen;
        scan_frame(24'h112233, 6'b000000);
        checkOutput("after discard frame2 valid", valid_seen - v0, 1);
        checkOutput("after discard o_digits", o_digits, 24'h112233);

        // Reset after five captured digits clears everything.
        scan_digits(24'h445566, 6'b000000, 1);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        checkOutput("midframe rst o_digits", o_digits, 0);
        checkOutput("midframe rst o_dp", o_dp, 0);
        checkOutput("midframe rst o_valid", o_valid, 0);
        checkOutput("midframe rst o_err", o_err, 0);
        checkOutput("midframe rst o_lost", o_lost, 0);
        v0 = valid_seen;
        applyStimulus(0, 4'h6, 1'b0, SETTLE);
        repeat (4) tick;
        scan_frame(24'h445566, 6'b000000);
        checkOutput("post rst frame1 valid", valid_seen - v0, 0);
        v0 = valid_seen;
        scan_frame(24'h445566, 6'b000000);
        checkOutput("post rst frame2 valid", valid_seen - v0, 1);
        checkOutput("post rst o_digits", o_digits, 24'h445566);

        checkOutput("err pulse width", err_wide, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
